granule_stream_scheduler: RTL and testbench

- Sequences the per-granule, per-channel sample streams from the two IMDCT/overlap-add channel sources into the single shared frequency-inversion stage.
- Order within a frame is gr0/ch0, gr0/ch1, gr1/ch0, gr1/ch1; ch1 segments are skipped for mono.
- Pulses the datapath's new_frame_start before every 576-sample segment so its sb/idx counters realign.
- Tags each forwarded sample with channel, granule and sample index for the polyphase stage.

---
 rtl/granule_sched_pkg.sv | 15 +
 rtl/granule_stream_scheduler.sv | 156 +++++++++++++++
 tb/tb_granule_stream_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/granule_sched_pkg.sv
// Shared types and frame-geometry constants for the granule stream scheduler.
package granule_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam int SAMPLES_PER_GR = 576;
  localparam int NUM_GR         = 2;
  localparam int SB_LEN         = 18;
  localparam int NUM_SB         = 32;

endpackage

// File: rtl/granule_stream_scheduler.sv
// Muxes the two channel sample streams into the shared inversion stage in
// gr0/ch0, gr0/ch1, gr1/ch0, gr1/ch1 order, tagging each beat and framing segments.
//
// state  | meaning
// IDLE   | no frame in flight, readies low
// START  | segment setup; new_frame_start pulse issued on exit
// STREAM | forwarding 576 beats from the selected channel
module granule_stream_scheduler
  import granule_sched_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int SAMPLES_PER_GR = 576,
  parameter int NUM_GR         = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start_in,
  input  logic              stereo_in,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic              ch0_valid,
  output logic              ch0_ready,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic              ch1_valid,
  output logic              ch1_ready,
  input  logic              dn_ready,
  output logic              inv_frame_start,
  output logic [DATA_W-1:0] inv_x,
  output logic              inv_x_valid,
  output logic              ch_out,
  output logic              gr_out,
  output logic [9:0]        sample_idx_out,
  output logic              granule_done,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              busy
);

  localparam logic [9:0] LAST_IDX = 10'(SAMPLES_PER_GR - 1);
  localparam logic       LAST_GR  = 1'(NUM_GR - 1);

  state_t      state;
  logic        stereo_r;
  logic        gr;
  logic        ch;
  logic [9:0]  cnt;

  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              xfer;
  logic              seg_end;
  logic              gran_end;
  logic              frame_end;

  assign sel_valid = ch ? ch1_valid : ch0_valid;
  assign sel_data  = ch ? ch1_data : ch0_data;
  assign xfer      = (state == STREAM) && sel_valid && dn_ready;
  assign seg_end   = xfer && (cnt == LAST_IDX);
  assign gran_end  = seg_end && (ch || !stereo_r);
  assign frame_end = gran_end && (gr == LAST_GR);

  assign ch0_ready = (state == STREAM) && !ch && dn_ready;
  assign ch1_ready = (state == STREAM) && ch && dn_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      stereo_r        <= 1'b0;
      gr              <= 1'b0;
      ch              <= 1'b0;
      cnt             <= '0;
      inv_frame_start <= 1'b0;
      inv_x           <= '0;
      inv_x_valid     <= 1'b0;
      ch_out          <= 1'b0;
      gr_out          <= 1'b0;
      sample_idx_out  <= '0;
      granule_done    <= 1'b0;
      frame_done      <= 1'b0;
      frame_abort     <= 1'b0;
    end else begin
      inv_frame_start <= 1'b0;
      inv_x_valid     <= xfer;
      granule_done    <= 1'b0;
      frame_done      <= 1'b0;
      frame_abort     <= 1'b0;

      if (xfer) begin
        inv_x          <= sel_data;
        ch_out         <= ch;
        gr_out         <= gr;
        sample_idx_out <= cnt;
      end

      case (state)
        IDLE: begin
          if (frame_start_in) begin
            stereo_r <= stereo_in;
            gr       <= 1'b0;
            ch       <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          cnt <= '0;
          // A restart here stays in START so the pulse is issued only once.
          if (frame_start_in) begin
            stereo_r    <= stereo_in;
            gr          <= 1'b0;
            ch          <= 1'b0;
            frame_abort <= 1'b1;
          end else begin
            inv_frame_start <= 1'b1;
            state           <= STREAM;
          end
        end

        STREAM: begin
          if (xfer) cnt <= seg_end ? 10'd0 : cnt + 10'd1;

          if (frame_start_in && !frame_end) begin
            stereo_r    <= stereo_in;
            gr          <= 1'b0;
            ch          <= 1'b0;
            frame_abort <= 1'b1;
            state       <= START;
          end else if (seg_end) begin
            granule_done <= gran_end;
            frame_done   <= frame_end;
            if (frame_end) begin
              gr <= 1'b0;
              ch <= 1'b0;
              if (frame_start_in) begin
                stereo_r <= stereo_in;
                state    <= START;
              end else begin
                state <= IDLE;
              end
            end else if (!ch && stereo_r) begin
              ch    <= 1'b1;
              state <= START;
            end else begin
              ch    <= 1'b0;
              gr    <= gr + 1'b1;
              state <= START;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_granule_stream_scheduler.sv
// Scoreboard bench: expected beats are queued per frame and checked as inv_x_valid appears.
module tb_granule_stream_scheduler;

  typedef struct {
    logic [31:0] data;
    logic        ch;
    logic        gr;
    logic [9:0]  idx;
    logic        gd;
    logic        fd;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start_in = 1'b0;
  logic        stereo_in = 1'b0;
  logic [31:0] ch0_data = '0;
  logic        ch0_valid = 1'b0;
  logic        ch0_ready;
  logic [31:0] ch1_data = '0;
  logic        ch1_valid = 1'b0;
  logic        ch1_ready;
  logic        dn_ready = 1'b0;
  logic        inv_frame_start;
  logic [31:0] inv_x;
  logic        inv_x_valid;
  logic        ch_out;
  logic        gr_out;
  logic [9:0]  sample_idx_out;
  logic        granule_done;
  logic        frame_done;
  logic        frame_abort;
  logic        busy;

  granule_stream_scheduler #(.DATA_W(32), .SAMPLES_PER_GR(576), .NUM_GR(2)) dut (
    .clk(clk), .rst(rst), .frame_start_in(frame_start_in), .stereo_in(stereo_in),
    .ch0_data(ch0_data), .ch0_valid(ch0_valid), .ch0_ready(ch0_ready),
    .ch1_data(ch1_data), .ch1_valid(ch1_valid), .ch1_ready(ch1_ready),
    .dn_ready(dn_ready), .inv_frame_start(inv_frame_start), .inv_x(inv_x),
    .inv_x_valid(inv_x_valid), .ch_out(ch_out), .gr_out(gr_out),
    .sample_idx_out(sample_idx_out), .granule_done(granule_done),
    .frame_done(frame_done), .frame_abort(frame_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail = 0;
  beat_t sb[$];
  int    m0 = 0, m1 = 0;   // next source index assigned to the model
  int    k0 = 0, k1 = 0;   // next source index the drivers present
  logic  hs0 = 1'b0, hs1 = 1'b0;
  bit    rand_mode = 0;
  bit    cur_stereo = 0;
  int    n_fs = 0, n_gd = 0, n_fd = 0, n_ab = 0, n_beats = 0;

  function automatic logic [31:0] mk(input int c, input int k);
    return {(c != 0) ? 16'hC1C1 : 16'hC0C0, 16'(k)};
  endfunction

  task automatic push_frame(input bit st);
    for (int g = 0; g < 2; g++)
      for (int c = 0; c < (st ? 2 : 1); c++)
        for (int i = 0; i < 576; i++) begin
          beat_t b;
          b.data = mk(c, (c != 0) ? m1 : m0);
          if (c != 0) m1++; else m0++;
          b.ch  = 1'(c);
          b.gr  = 1'(g);
          b.idx = 10'(i);
          b.gd  = (i == 575) && (c == 1 || !st);
          b.fd  = b.gd && (g == 1);
          sb.push_back(b);
        end
  endtask

  // Handshakes are sampled at the active edge, sources advance on the falling edge.
  always @(posedge clk) begin
    hs0 <= ch0_valid && ch0_ready;
    hs1 <= ch1_valid && ch1_ready;
  end

  always @(negedge clk) begin
    if (hs0) k0++;
    if (hs1) k1++;
    ch0_valid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    ch1_valid = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    dn_ready  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    ch0_data  = mk(0, k0);
    ch1_data  = mk(1, k1);
  end

  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if (ch0_ready && ch1_ready) begin
        n_fail++;
        $display("FAIL both_ready ch0_ready=%b ch1_ready=%b expected not both high", ch0_ready, ch1_ready);
      end
      n_checks++;
      if (!cur_stereo && ch1_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL mono_ch1_ready got %b expected 0", ch1_ready);
      end
      n_checks++;
      if (inv_frame_start && inv_x_valid) begin
        n_fail++;
        $display("FAIL fs_with_valid inv_frame_start=%b inv_x_valid=%b expected not coincident", inv_frame_start, inv_x_valid);
      end
      if (inv_frame_start) n_fs++;
      if (frame_abort) n_ab++;
      if (granule_done) n_gd++;
      if (frame_done) n_fd++;
      if (inv_x_valid) begin
        n_beats++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat got data %h with empty scoreboard", inv_x);
        end else begin
          beat_t e;
          e = sb.pop_front();
          if (inv_x !== e.data || ch_out !== e.ch || gr_out !== e.gr || sample_idx_out !== e.idx ||
              granule_done !== e.gd || frame_done !== e.fd) begin
            n_fail++;
            $display("FAIL beat got data=%h ch=%b gr=%b idx=%0d gd=%b fd=%b expected data=%h ch=%b gr=%b idx=%0d gd=%b fd=%b",
                     inv_x, ch_out, gr_out, sample_idx_out, granule_done, frame_done,
                     e.data, e.ch, e.gr, e.idx, e.gd, e.fd);
          end
        end
      end else begin
        n_checks++;
        if (granule_done || frame_done) begin
          n_fail++;
          $display("FAIL done_without_beat gd=%b fd=%b expected 0 0", granule_done, frame_done);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame(input bit st);
    step();
    cur_stereo     = st;
    push_frame(st);
    frame_start_in = 1'b1;
    stereo_in      = st;
    step();
    frame_start_in = 1'b0;
  endtask

  task automatic run_until_idle(output bit ok);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 20000) begin
      step();
      n++;
    end
    repeat (3) step();
    ok = (sb.size() == 0) && !busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({inv_frame_start, inv_x_valid, ch_out, gr_out, granule_done, frame_done, frame_abort,
         busy, ch0_ready, ch1_ready} !== 10'b0 || inv_x !== 32'h0 || sample_idx_out !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got x=%h idx=%0d busy=%b valid=%b expected all 0", inv_x, sample_idx_out, busy, inv_x_valid);
    end
    rst = 1'b0;
    repeat (3) step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle busy got %b expected 0", busy);
    end
  endtask

  task automatic test_frame(input bit st, input bit rnd);
    int fs0, gd0, fd0, ab0, bt0;
    bit ok;
    rand_mode = rnd;
    fs0 = n_fs; gd0 = n_gd; fd0 = n_fd; ab0 = n_ab; bt0 = n_beats;
    start_frame(st);
    run_until_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL frame_timeout left %0d beats busy=%b expected 0 and 0", sb.size(), busy);
    end
    n_checks++;
    if (n_fs - fs0 != (st ? 4 : 2) || n_beats - bt0 != (st ? 2304 : 1152)) begin
      n_fail++;
      $display("FAIL frame_counts fs=%0d beats=%0d expected %0d %0d", n_fs - fs0, n_beats - bt0, st ? 4 : 2, st ? 2304 : 1152);
    end
    n_checks++;
    if (n_gd - gd0 != 2 || n_fd - fd0 != 1 || n_ab - ab0 != 0) begin
      n_fail++;
      $display("FAIL frame_pulses gd=%0d fd=%0d ab=%0d expected 2 1 0", n_gd - gd0, n_fd - fd0, n_ab - ab0);
    end
    rand_mode = 0;
  endtask

  task automatic test_abort();
    int fs0, gd0, fd0, ab0, bt0, fb0, fb1, n;
    bit ok;
    rand_mode = 0;
    fs0 = n_fs; gd0 = n_gd; fd0 = n_fd; ab0 = n_ab; bt0 = n_beats;
    fb0 = m0; fb1 = m1;
    start_frame(1);
    n = 0;
    while (!(ch1_ready && ch1_valid && k1 == fb1 + 300) && n < 5000) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 5000) begin
      n_fail++;
      $display("FAIL abort_reach ch1 beat 300 not reached, k1=%0d expected %0d", k1, fb1 + 300);
    end
    frame_start_in = 1'b1;
    stereo_in      = 1'b1;
    while (sb.size() != 0 && !(sb[$].ch == 1'b1 && sb[$].gr == 1'b0 && sb[$].idx == 10'd300))
      void'(sb.pop_back());
    m0 = fb0 + 576;
    m1 = fb1 + 301;
    push_frame(1);
    step();
    frame_start_in = 1'b0;
    run_until_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL abort_timeout left %0d beats busy=%b expected 0 and 0", sb.size(), busy);
    end
    n_checks++;
    if (n_ab - ab0 != 1 || n_fd - fd0 != 1 || n_gd - gd0 != 2) begin
      n_fail++;
      $display("FAIL abort_pulses ab=%0d fd=%0d gd=%0d expected 1 1 2", n_ab - ab0, n_fd - fd0, n_gd - gd0);
    end
    n_checks++;
    if (n_fs - fs0 != 6 || n_beats - bt0 != 576 + 301 + 2304) begin
      n_fail++;
      $display("FAIL abort_counts fs=%0d beats=%0d expected 6 %0d", n_fs - fs0, n_beats - bt0, 576 + 301 + 2304);
    end
  endtask

  task automatic test_back_to_back();
    int fs0, fd0, ab0, bt0, fb0, n;
    bit ok;
    rand_mode = 0;
    fs0 = n_fs; fd0 = n_fd; ab0 = n_ab; bt0 = n_beats;
    fb0 = m0;
    start_frame(0);
    n = 0;
    while (!(ch0_ready && ch0_valid && k0 == fb0 + 1151) && n < 5000) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 5000) begin
      n_fail++;
      $display("FAIL b2b_reach final beat not reached, k0=%0d expected %0d", k0, fb0 + 1151);
    end
    push_frame(0);
    frame_start_in = 1'b1;
    stereo_in      = 1'b0;
    step();
    frame_start_in = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_handover busy=%b frame_done=%b expected 1 1", busy, frame_done);
    end
    run_until_idle(ok);
    n_checks++;
    if (!ok || n_fd - fd0 != 2 || n_ab - ab0 != 0 || n_fs - fs0 != 4 || n_beats - bt0 != 2304) begin
      n_fail++;
      $display("FAIL b2b_counts ok=%b fd=%0d ab=%0d fs=%0d beats=%0d expected 1 2 0 4 2304",
               ok, n_fd - fd0, n_ab - ab0, n_fs - fs0, n_beats - bt0);
    end
  endtask

  task automatic test_reset_mid();
    int fs0, gd0, fd0, ab0, bt0, fb0, n;
    rand_mode = 0;
    fb0 = m0;
    start_frame(1);
    n = 0;
    while (!(ch0_ready && ch0_valid && k0 == fb0 + 100) && n < 5000) begin
      step();
      n++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({inv_frame_start, inv_x_valid, ch_out, gr_out, granule_done, frame_done, frame_abort,
         busy, ch0_ready, ch1_ready} !== 10'b0 || inv_x !== 32'h0 || sample_idx_out !== 10'h0) begin
      n_fail++;
      $display("FAIL mid_reset got x=%h idx=%0d busy=%b valid=%b ready=%b%b expected all 0",
               inv_x, sample_idx_out, busy, inv_x_valid, ch0_ready, ch1_ready);
    end
    sb.delete();
    repeat (3) step();
    rst = 1'b0;
    m0 = k0;
    m1 = k1;
    fs0 = n_fs; gd0 = n_gd; fd0 = n_fd; ab0 = n_ab; bt0 = n_beats;
    repeat (20) step();
    n_checks++;
    if (busy !== 1'b0 || n_fs != fs0 || n_gd != gd0 || n_fd != fd0 || n_ab != ab0 || n_beats != bt0) begin
      n_fail++;
      $display("FAIL post_reset_quiet busy=%b pulses fs=%0d gd=%0d fd=%0d ab=%0d beats=%0d expected all 0",
               busy, n_fs - fs0, n_gd - gd0, n_fd - fd0, n_ab - ab0, n_beats - bt0);
    end
  endtask

  initial begin
    test_reset();
    test_frame(1, 0);
    test_frame(0, 0);
    test_frame(1, 1);
    test_frame(0, 1);
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_frame(0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
